// File: rtl/fir_jtag_tap.sv
// Single-clock 16-state TAP that loads and reads back the 48-bit FIR config word.
// The IR selects IDCODE, LOAD_CFG, READ_CFG or BYPASS. A committed word raises cfg_valid for one cycle.
module fir_jtag_tap #(
  parameter int          IR_W   = 4,
  parameter int          CFG_W  = 48,
  parameter logic [31:0] IDCODE = 32'h0F100001
) (
  input  logic             w_clk,
  input  logic             w_rstn,
  input  logic             tms,
  input  logic             tdi,
  output logic             tdo,
  output logic             tdo_en,
  output logic [CFG_W-1:0] cfg_data,
  output logic             cfg_valid,
  output logic [IR_W-1:0]  ir_q,
  output logic [3:0]       tap_state
);

  // state | meaning
  // TLR   | test-logic-reset, IR forced to IDCODE
  // RTI   | run-test/idle
  // SEL_x | select DR/IR scan
  // CAP_x | capture into shift reg
  // SHF_x | shift one bit per edge
  // EX1_x | exit1, PAU_x pause hold, EX2_x exit2
  // UPD_x | update, commits shift reg
  typedef enum logic [3:0] {
    EX2_DR = 4'h0, EX1_DR = 4'h1, SHF_DR = 4'h2, PAU_DR = 4'h3,
    SEL_IR = 4'h4, UPD_DR = 4'h5, CAP_DR = 4'h6, SEL_DR = 4'h7,
    EX2_IR = 4'h8, EX1_IR = 4'h9, SHF_IR = 4'hA, PAU_IR = 4'hB,
    RTI    = 4'hC, UPD_IR = 4'hD, CAP_IR = 4'hE, TLR    = 4'hF
  } tap_t;

  typedef enum logic [1:0] {CH_ID, CH_CFG, CH_BYP} chain_t;

  localparam logic [IR_W-1:0] INS_IDCODE = IR_W'(4'h1);
  localparam logic [IR_W-1:0] INS_LOAD   = IR_W'(4'h2);
  localparam logic [IR_W-1:0] INS_READ   = IR_W'(4'h3);

  tap_t             state;
  tap_t             state_nxt;
  chain_t           chain;
  logic [IR_W-1:0]  ir_sreg;
  logic [CFG_W-1:0] dr_sreg;

  always_comb begin
    state_nxt = state;
    case (state)
      TLR:     state_nxt = tms ? TLR    : RTI;
      RTI:     state_nxt = tms ? SEL_DR : RTI;
      SEL_DR:  state_nxt = tms ? SEL_IR : CAP_DR;
      CAP_DR:  state_nxt = tms ? EX1_DR : SHF_DR;
      SHF_DR:  state_nxt = tms ? EX1_DR : SHF_DR;
      EX1_DR:  state_nxt = tms ? UPD_DR : PAU_DR;
      PAU_DR:  state_nxt = tms ? EX2_DR : PAU_DR;
      EX2_DR:  state_nxt = tms ? UPD_DR : SHF_DR;
      UPD_DR:  state_nxt = tms ? SEL_DR : RTI;
      SEL_IR:  state_nxt = tms ? TLR    : CAP_IR;
      CAP_IR:  state_nxt = tms ? EX1_IR : SHF_IR;
      SHF_IR:  state_nxt = tms ? EX1_IR : SHF_IR;
      EX1_IR:  state_nxt = tms ? UPD_IR : PAU_IR;
      PAU_IR:  state_nxt = tms ? EX2_IR : PAU_IR;
      EX2_IR:  state_nxt = tms ? UPD_IR : SHF_IR;
      UPD_IR:  state_nxt = tms ? SEL_DR : RTI;
      default: state_nxt = TLR;
    endcase
  end

  // Undefined instruction codes fall through to the 1-bit bypass chain.
  always_comb begin
    chain = CH_BYP;
    if (ir_q == INS_IDCODE)
      chain = CH_ID;
    else if (ir_q == INS_LOAD || ir_q == INS_READ)
      chain = CH_CFG;
  end

  always_ff @(posedge w_clk) begin
    if (!w_rstn) begin
      state     <= TLR;
      ir_q      <= INS_IDCODE;
      ir_sreg   <= '0;
      dr_sreg   <= '0;
      cfg_data  <= '0;
      cfg_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      cfg_valid <= 1'b0;
      case (state)
        CAP_IR: ir_sreg <= IR_W'(1);
        SHF_IR: ir_sreg <= {tdi, ir_sreg[IR_W-1:1]};
        UPD_IR: ir_q    <= ir_sreg;
        CAP_DR: begin
          if (chain == CH_ID)
            dr_sreg <= {{(CFG_W-32){1'b0}}, IDCODE};
          else if (ir_q == INS_READ)
            dr_sreg <= cfg_data;
          else
            dr_sreg <= '0;
        end
        SHF_DR: begin
          case (chain)
            CH_ID:   dr_sreg <= {{(CFG_W-32){1'b0}}, tdi, dr_sreg[31:1]};
            CH_CFG:  dr_sreg <= {tdi, dr_sreg[CFG_W-1:1]};
            default: dr_sreg <= {{(CFG_W-1){1'b0}}, tdi};
          endcase
        end
        UPD_DR: begin
          if (ir_q == INS_LOAD) begin
            cfg_data  <= dr_sreg;
            cfg_valid <= 1'b1;
          end
        end
        default: ;
      endcase
      // Any path back into TLR restores the IDCODE instruction.
      if (state_nxt == TLR)
        ir_q <= INS_IDCODE;
    end
  end

  assign tdo_en    = (state == SHF_DR) || (state == SHF_IR);
  assign tdo       = (state == SHF_DR) ? dr_sreg[0] :
                     (state == SHF_IR) ? ir_sreg[0] : 1'b0;
  assign tap_state = state;

endmodule

// File: tb/tb_fir_jtag_tap.sv
// Bench for fir_jtag_tap: a table-driven TAP model is compared with every output on every cycle.
// Directed scans pin the model to literal values, and randomized tms/tdi/reset traffic follows them.
module tb_fir_jtag_tap;
  localparam logic [31:0] IDC = 32'h0F100001;
  localparam logic [3:0] S_TLR = 4'hF, S_RTI = 4'hC, S_SDR = 4'h7, S_CDR = 4'h6,
                         S_SHD = 4'h2, S_X1D = 4'h1, S_PD = 4'h3, S_X2D = 4'h0,
                         S_UD = 4'h5, S_SIR = 4'h4, S_CIR = 4'hE, S_SHI = 4'hA,
                         S_X1I = 4'h9, S_PI = 4'hB, S_X2I = 4'h8, S_UI = 4'hD;

  logic        w_clk = 1'b0;
  logic        w_rstn, tms, tdi;
  logic        tdo, tdo_en, cfg_valid;
  logic [47:0] cfg_data;
  logic [3:0]  ir_q, tap_state;

  fir_jtag_tap dut (
    .w_clk(w_clk), .w_rstn(w_rstn), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .ir_q(ir_q), .tap_state(tap_state)
  );

  always #5 w_clk = ~w_clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model
  logic [3:0]  nx0 [16];
  logic [3:0]  nx1 [16];
  logic [3:0]  m_st, m_ir, m_irsr;
  logic [63:0] m_dr;
  logic [47:0] m_cfg;
  logic        m_vld;

  task automatic arc(input logic [3:0] s, input logic [3:0] on0, input logic [3:0] on1);
    nx0[s] = on0;
    nx1[s] = on1;
  endtask

  function automatic int dr_len(input logic [3:0] ins);
    case (ins)
      4'h1:       return 32;
      4'h2, 4'h3: return 48;
      default:    return 1;
    endcase
  endfunction

  task automatic model_edge(input logic r, input logic m, input logic d);
    int len;
    logic [3:0] nst;
    if (!r) begin
      m_st = S_TLR; m_ir = 4'h1; m_irsr = 4'h0; m_dr = 64'h0; m_cfg = 48'h0; m_vld = 1'b0;
      return;
    end
    m_vld = 1'b0;
    len = dr_len(m_ir);
    if (m_st == S_CIR) m_irsr = 4'b0001;
    if (m_st == S_SHI) m_irsr = {d, m_irsr[3:1]};
    if (m_st == S_UI) m_ir = m_irsr;
    if (m_st == S_CDR) m_dr = (m_ir == 4'h1) ? 64'(IDC) : (m_ir == 4'h3) ? 64'(m_cfg) : 64'h0;
    if (m_st == S_SHD)
      m_dr = ((m_dr >> 1) | (64'(d) << (len - 1))) & ((64'd1 << len) - 64'd1);
    if (m_st == S_UD && m_ir == 4'h2) begin
      m_cfg = m_dr[47:0];
      m_vld = 1'b1;
    end
    nst = m ? nx1[m_st] : nx0[m_st];
    if (nst == S_TLR) m_ir = 4'h1;
    m_st = nst;
  endtask

  task automatic compare_all();
    logic e_tdo, e_en;
    logic [57:0] act, exp;
    e_en  = (m_st == S_SHD) || (m_st == S_SHI);
    e_tdo = (m_st == S_SHD) ? m_dr[0] : (m_st == S_SHI) ? m_irsr[0] : 1'b0;
    act = {tap_state, ir_q, tdo, tdo_en, cfg_valid, cfg_data};
    exp = {m_st, m_ir, e_tdo, e_en, m_vld, m_cfg};
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL outputs t=%0t got st=%h ir=%h tdo=%b en=%b vld=%b cfg=%h want st=%h ir=%h tdo=%b en=%b vld=%b cfg=%h",
               $time, tap_state, ir_q, tdo, tdo_en, cfg_valid, cfg_data,
               m_st, m_ir, e_tdo, e_en, m_vld, m_cfg);
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // one clock: drive, let the edge happen, advance model, compare on the falling edge
  task automatic step(input logic r, input logic m, input logic d);
    w_rstn = r; tms = m; tdi = d;
    @(posedge w_clk);
    model_edge(r, m, d);
    @(negedge w_clk);
    compare_all();
  endtask

  task automatic load_ir(input logic [3:0] code);
    step(1, 1, 0); step(1, 1, 0); step(1, 0, 0); step(1, 0, 0);
    for (int i = 0; i < 4; i++) step(1, i == 3, code[i]);
    step(1, 1, 0); step(1, 0, 0);
  endtask

  task automatic shift_dr(input int n, input logic [63:0] din, output logic [63:0] dout);
    dout = 64'h0;
    step(1, 1, 0); step(1, 0, 0); step(1, 0, 0);
    for (int i = 0; i < n; i++) begin
      dout[i] = tdo;
      step(1, i == n - 1, din[i]);
    end
    step(1, 1, 0); step(1, 0, 0);
  endtask

  logic [63:0] got;
  logic [63:0] rnd;
  logic [3:0]  ins;

  initial begin
    arc(S_TLR, S_RTI, S_TLR); arc(S_RTI, S_RTI, S_SDR); arc(S_SDR, S_CDR, S_SIR);
    arc(S_CDR, S_SHD, S_X1D); arc(S_SHD, S_SHD, S_X1D); arc(S_X1D, S_PD, S_UD);
    arc(S_PD, S_PD, S_X2D);   arc(S_X2D, S_SHD, S_UD);  arc(S_UD, S_RTI, S_SDR);
    arc(S_SIR, S_CIR, S_TLR); arc(S_CIR, S_SHI, S_X1I); arc(S_SHI, S_SHI, S_X1I);
    arc(S_X1I, S_PI, S_UI);   arc(S_PI, S_PI, S_X2I);   arc(S_X2I, S_SHI, S_UI);
    arc(S_UI, S_RTI, S_SDR);

    // reset state
    step(0, 0, 0); step(0, 0, 0);
    chk("rst_state", 64'(tap_state), 64'hF);
    chk("rst_ir", 64'(ir_q), 64'h1);
    chk("rst_cfg", 64'(cfg_data), 64'h0);
    chk("rst_tdo_en", 64'(tdo_en), 64'h0);

    // five tms=1 from SHIFT_DR return to TLR and restore IDCODE
    step(1, 0, 0);
    load_ir(4'hF);
    chk("ir_bypass", 64'(ir_q), 64'hF);
    step(1, 1, 0); step(1, 0, 0); step(1, 0, 0);
    chk("in_shift_dr", 64'(tap_state), 64'h2);
    for (int i = 0; i < 5; i++) step(1, 1, 0);
    chk("tlr_recover", 64'(tap_state), 64'hF);
    chk("tlr_ir", 64'(ir_q), 64'h1);

    // IDCODE readout
    step(1, 0, 0);
    rnd = {$urandom, $urandom};
    shift_dr(32, rnd, got);
    chk("idcode", got, 64'h0F100001);

    // reset after 20 bits of LOAD_CFG discards the partial word
    load_ir(4'h2);
    step(1, 1, 0); step(1, 0, 0); step(1, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 0, 1'($urandom));
    step(0, 0, 0);
    chk("midrst_state", 64'(tap_state), 64'hF);
    chk("midrst_cfg", 64'(cfg_data), 64'h0);
    chk("midrst_vld", 64'(cfg_valid), 64'h0);

    // LOAD_CFG commit and single-cycle strobe
    step(1, 0, 0);
    load_ir(4'h2);
    chk("ir_load", 64'(ir_q), 64'h2);
    shift_dr(48, 64'h8312D6EEFAED, got);
    chk("load_vld_hi", 64'(cfg_valid), 64'h1);
    chk("load_cfg", 64'(cfg_data), 64'h8312D6EEFAED);
    step(1, 0, 0);
    chk("load_vld_lo", 64'(cfg_valid), 64'h0);

    // READ_CFG returns the committed word and leaves it untouched
    load_ir(4'h3);
    rnd = {$urandom, $urandom};
    shift_dr(48, rnd, got);
    chk("read_cfg", got, 64'h8312D6EEFAED);
    chk("read_keeps_cfg", 64'(cfg_data), 64'h8312D6EEFAED);

    // BYPASS: tdi 1,0,1,1 -> tdo 0,1,0,1
    load_ir(4'hF);
    shift_dr(4, 64'b1101, got);
    chk("bypass", got, 64'b1010);

    // 24-bit short shift split by PAUSE: partial word lands left-justified
    load_ir(4'h2);
    rnd = 64'hA5C396;
    step(1, 1, 0); step(1, 0, 0); step(1, 0, 0);
    for (int i = 0; i < 16; i++) step(1, i == 15, rnd[i]);
    step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
    step(1, 1, 0); step(1, 0, 0);
    for (int i = 0; i < 8; i++) step(1, i == 7, rnd[16 + i]);
    step(1, 1, 0); step(1, 0, 0);
    chk("short_pause", 64'(cfg_data), 64'hA5C396000000);

    // 52-bit over-long shift: the last 48 bits win
    shift_dr(52, 64'h123456789ABCD, got);
    chk("long_shift", 64'(cfg_data), 64'h123456789ABC);

    // randomized traffic from assorted instructions
    for (int b = 0; b < 10; b++) begin
      for (int i = 0; i < 5; i++) step(1, 1, 0);
      step(1, 0, 0);
      case ($urandom_range(0, 4))
        0: ins = 4'h1;
        1: ins = 4'h2;
        2: ins = 4'h3;
        3: ins = 4'hF;
        default: ins = 4'($urandom);
      endcase
      load_ir(ins);
      for (int i = 0; i < 300; i++)
        step(($urandom_range(0, 249) != 0), ($urandom_range(0, 99) < 30), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
